// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add; DIV/DIVU use restoring division on magnitudes, with signs fixed up at the end.
module muldiv_unit #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 is_div_q, is_div_d;
  logic                 div0_q, div0_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, div_next;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  // Upper half of acc is the running product or partial remainder.
  // Lower half is the multiplier or the dividend/quotient.
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
    b_mag     = (signed_op && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // The partial remainder needs WIDTH+1 bits only until it has been compared against the divisor.
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub   = rem_shift[WIDTH-1:0] - b_q;
    div_next  = (rem_shift >= {1'b0, b_q})
              ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
              : {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          b_d       = b_mag;
          neg_res_d = signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
          neg_rem_d = signed_op & opa[WIDTH-1];
          cnt_d     = '0;
          if (op[1] && (opb == '0)) begin
            // Keep the raw dividend so that it can be returned in HI.
            div0_d  = 1'b1;
            acc_d   = {{WIDTH{1'b0}}, opa};
            state_d = FIX;
          end else begin
            div0_d  = 1'b0;
            state_d = CALC;
          end
        end else begin
          if (mthi) hi_d = opa;
          if (mtlo) lo_d = opa;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (div0_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = DIV0_LO;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected HI/LO and busy length per operation,
// and a negedge monitor compares them whenever done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, cancel, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;

  muldiv_unit dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .opa(opa), .opb(opb),
    .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: u = sa * sb;
      2'b01: u = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) u = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          u = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) u = {a, 32'hFFFFFFFF};
        else        u = {a % b, a / b};
      end
    endcase
    return u;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      busy_cnt = 0;
    end else if (done) begin
      check("busy_during_done", busy, 0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_hi", hi, e.hi);
        check("sb_lo", lo, e.lo);
        check("sb_busy_cycles", busy_cnt, e.cycles);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    logic [63:0] m;
    exp_t        e;
    @(negedge clk);
    if (expect_it) begin
      m        = model(o, a, b);
      e.hi     = m[63:32];
      e.lo     = m[31:0];
      e.cycles = (o[1] && b == 0) ? 1 : 33;
      sb_q.push_back(e);
    end
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, (n < 100), 1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
    issue(o, a, b, 1'b1);
    wait_done(name);
  endtask

  function automatic logic [31:0] pick_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h80000000;
      1: v = 32'hFFFFFFFF;
      2: v = 32'($urandom_range(0, 15));
      3: v = 32'h7FFFFFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] a, b, lo_before;
    logic [1:0]  o;
    int          done_seen;

    resetn = 1'b1; start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    resetn = 1'b0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    check("multu_max_hi", hi, 32'hFFFFFFFE);
    check("multu_max_lo", lo, 32'h00000001);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    run_op(2'b00, 32'hFFFFFFFD, 32'd5, "mult_neg");
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFF1);
    run_op(2'b00, 32'h80000000, 32'h80000000, "mult_min");
    check("mult_min_hi", hi, 32'h40000000);
    check("mult_min_lo", lo, 32'h0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, "div_neg");
    check("div_neg_lo", lo, 32'hFFFFFFFD);
    check("div_neg_hi", hi, 32'hFFFFFFFF);
    run_op(2'b11, 32'd7, 32'd2, "divu_7_2");
    check("divu_7_2_lo", lo, 32'd3);
    check("divu_7_2_hi", hi, 32'd1);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h0);
    run_op(2'b11, 32'd5, 32'd0, "divu_zero");
    check("divu_zero_hi", hi, 32'd5);
    check("divu_zero_lo", lo, 32'hFFFFFFFF);

    @(negedge clk); mtlo = 1'b1; opa = 32'h1234;
    @(negedge clk); mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi_kept", hi, 32'd5);
    mthi = 1'b1; mtlo = 1'b1; opa = 32'hCAFEF00D;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    check("mt_both_hi", hi, 32'hCAFEF00D);
    check("mt_both_lo", lo, 32'hCAFEF00D);

    // start beats a move issued in the same idle cycle.
    sb_q.push_back('{hi: 32'd0, lo: 32'd6, cycles: 33});
    start = 1'b1; mthi = 1'b1; op = 2'b01; opa = 32'd2; opb = 32'd3;
    @(negedge clk); start = 1'b0; mthi = 1'b0;
    wait_done("start_vs_mthi");

    // Cancel at E10 leaves hi/lo untouched and never pulses done.
    @(negedge clk); mthi = 1'b1; opa = 32'hAAAA5555;
    @(negedge clk); mthi = 1'b0;
    check("preload_hi", hi, 32'hAAAA5555);
    lo_before = lo;
    issue(2'b00, 32'd7, 32'd9, 1'b0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_done", done, 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("cancel_no_done", done_seen, 0);
    check("cancel_hi", hi, 32'hAAAA5555);
    check("cancel_lo", lo, lo_before);

    // start and mthi while busy are ignored; the original operation completes.
    issue(2'b00, 32'h12345678, 32'hFEDCBA98, 1'b1);
    repeat (5) begin
      start = 1'b1; mthi = 1'b1; op = 2'b11; opa = 32'd1; opb = 32'd1;
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0;
    wait_done("start_while_busy");
    check("busy_start_hi", hi, model(2'b00, 32'h12345678, 32'hFEDCBA98) >> 32);

    // Reset at E15 of a DIVU clears outputs before the following edge.
    issue(2'b11, 32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk); resetn = 1'b0;
    run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7_lo", lo, 32'd14);
    check("divu_100_7_hi", hi, 32'd2);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_val();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_val();
      run_op(o, a, b, "random");
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS core.
- Sits directly downstream of the register file: its operand inputs take the register file's two read-data outputs (rs, rt).
- Executes MULT, MULTU, DIV and DIVU in 32 iterations and also supports MTHI/MTLO.
- hi/lo outputs feed the MFHI/MFLO writeback mux.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each, and the iteration count equals WIDTH.
- DIV0_LO, 32'hFFFFFFFF, value written to lo on divide-by-zero.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-high reset (name kept for codebase consistency; 1 = reset asserted)
- start  in  1  launch operation; sampled only while idle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- opa  in  WIDTH  rs operand (register file read port 1)
- opb  in  WIDTH  rt operand (register file read port 2)
- cancel  in  1  abort the in-flight operation
- mthi  in  1  write opa to hi
- mtlo  in  1  write opa to lo
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, level-sensitive):
  - hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
  - Asserting reset mid-operation aborts immediately; no hi/lo update occurs.
- States: IDLE, CALC, FIX.
- Edge numbering: E0 is the edge that samples start=1 in IDLE.
- IDLE + start at E0:
  - Latch op, |opa| and |opb| (magnitudes for signed ops, raw values for unsigned), plus the result sign flags.
  - Go to CALC; busy=1 from the cycle after E0.
- CALC, edges E1..E32, one radix-2 step per edge:
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; partial remainder is WIDTH+1 bits.
  - A 6-bit counter counts 0..31; after E32, go to FIX.
- FIX, edge E33:
  - Apply sign correction:
    - Product is negated if the operand signs differ (signed ops only).
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - Write hi/lo:
    - Multiply: hi = upper half, lo = lower half.
    - Divide: lo = quotient, hi = remainder.
  - Go to IDLE; busy=0 and done=1 in the cycle after E33.
- done is high for exactly one cycle, then returns to 0.
- Divide-by-zero (opb=0, DIV or DIVU) is detected at E0:
  - Skip CALC; at E1 write lo=DIV0_LO and hi=opa.
  - done=1 and busy=0 in the cycle after E1.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the magnitude algorithm with WIDTH-bit truncation; no special case is needed.
- Priority at any edge: reset > cancel > start > mthi/mtlo.
- cancel while busy: return to IDLE at the next edge; busy=0 and done=0 afterwards; hi/lo unchanged. cancel while idle has no effect.
- start while busy: ignored, with no queueing. The decoder holds start until busy=0.
- mthi/mtlo while busy: ignored.
- mthi/mtlo while idle and start=0: register opa into hi/lo at the next edge. Both may be asserted together.
- start and mthi/mtlo in the same idle cycle: start wins; the move is dropped.
- start in the same cycle that done is high: accepted, because the state is already IDLE.
- hi/lo change only at: reset, the FIX edge, the divide-by-zero completion edge, and mthi/mtlo edges.
- Operand inputs are not required to be stable after E0.

Test Plan:
- MULTU opa=0xFFFFFFFF, opb=0xFFFFFFFF → after E33: hi=0xFFFFFFFE, lo=0x00000001; done pulses one cycle; busy high for exactly 33 cycles.
- MULT opa=0xFFFFFFFD (-3), opb=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV opa=0xFFFFFFF9 (-7), opb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU opa=5, opb=0 → done in the cycle after E1, hi=5, lo=0xFFFFFFFF. Then mtlo with opa=0x1234 while idle → lo=0x1234 at the next edge.
- Preload hi=0xAAAA5555 via mthi. Start MULT, assert cancel at E10 → busy=0 next cycle, done never pulses, hi still 0xAAAA5555. Repeat with start re-asserted while busy → ignored.
- Assert resetn at E15 of a DIVU → outputs 0 asynchronously, before the next clk edge. Deassert, start DIVU 100/7 → lo=14, hi=2.
